// File: rtl/frame_ctrl_if.sv
// Byte-stream handshake bundle (data/vld/rdy) shared by the frame_ctrl input and output sides.
interface axis_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] data;
    logic         vld;
    logic         rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/frame_ctrl.sv
// Frame sequencer: hunts for SYNC, parses width/height, forwards width*height pixels with line/done pulses.
// Optional idle timeout in the header/pixel phases when FRAME_TIMEOUT_EN is defined.
module frame_ctrl #(
  parameter logic [31:0] SYNC    = 32'h4245_474E,
  parameter int unsigned DIM_W   = 32,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  axis_if.slave            axis_i,
  axis_if.master           axis_o,
  output logic [DIM_W-1:0] width,
  output logic [DIM_W-1:0] height,
  output logic             line,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {HUNT, WIDTH, HEIGHT, PIXELS} state_t;

  state_t           state_q, state_d;
  logic [23:0]      shreg;
  logic [1:0]       bcnt;
  logic [DIM_W-1:0] col, row;
  logic [7:0]       o_data;
  logic             o_vld;
  logic             in_rdy, acc, pix_acc;
  logic             sync_hit, zero_dim, last_col, last_row, err_d;
  logic [DIM_W-1:0] width_nxt, height_nxt;
  logic             timeout_hit;

  assign in_rdy   = (state_q == PIXELS) ? (!o_vld || axis_o.rdy) : 1'b1;
  assign acc      = axis_i.vld && in_rdy;
  assign pix_acc  = acc && (state_q == PIXELS);
  // Only the last three bytes need storing: the fourth sync byte is the incoming one.
  assign sync_hit = ({shreg, axis_i.data} == SYNC);

  // First header byte replaces the field so bits above the 32-bit field never survive.
  assign width_nxt  = (bcnt == 2'd0) ? DIM_W'(axis_i.data) : DIM_W'({width, axis_i.data});
  assign height_nxt = (bcnt == 2'd0) ? DIM_W'(axis_i.data) : DIM_W'({height, axis_i.data});
  assign zero_dim   = (width == '0) || (height_nxt == '0);
  assign last_col   = (col == width - DIM_W'(1));
  assign last_row   = (row == height - DIM_W'(1));

  assign axis_i.rdy  = in_rdy;
  assign axis_o.data = o_data;
  assign axis_o.vld  = o_vld;
  assign busy        = (state_q != HUNT);

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle;

  assign timeout_hit = (state_q != HUNT) && !acc && (idle == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle <= '0;
    end else if (state_q == HUNT || acc || timeout_hit) begin
      idle <= '0;
    end else begin
      idle <= idle + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      HUNT:   if (acc && sync_hit) state_d = WIDTH;
      WIDTH:  if (acc && bcnt == 2'd3) state_d = HEIGHT;
      HEIGHT: begin
        if (acc && bcnt == 2'd3) begin
          if (zero_dim) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            state_d = PIXELS;
          end
        end
      end
      PIXELS: if (pix_acc && last_col && last_row) state_d = HUNT;
      default: state_d = HUNT;
    endcase
    if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg  <= '0;
      bcnt   <= '0;
      width  <= '0;
      height <= '0;
      col    <= '0;
      row    <= '0;
      o_data <= '0;
      o_vld  <= 1'b0;
      line   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      line <= pix_acc && last_col;
      done <= pix_acc && last_col && last_row;
      err  <= err_d;

      if (state_q != HUNT) begin
        shreg <= '0;
      end else if (acc) begin
        shreg <= {shreg[15:0], axis_i.data};
      end

      if (acc && (state_q == WIDTH || state_q == HEIGHT)) begin
        bcnt <= bcnt + 2'd1;
      end else if (state_q == HUNT) begin
        bcnt <= '0;
      end

      if (acc && state_q == WIDTH)  width  <= width_nxt;
      if (acc && state_q == HEIGHT) height <= height_nxt;

      if (state_q != PIXELS) begin
        col <= '0;
        row <= '0;
      end else if (acc) begin
        if (last_col) begin
          col <= '0;
          row <= row + DIM_W'(1);
        end else begin
          col <= col + DIM_W'(1);
        end
      end

      // Output register keeps draining after the frame ends; only PIXELS loads it.
      if (pix_acc) begin
        o_data <= axis_i.data;
        o_vld  <= 1'b1;
      end else if (axis_o.rdy) begin
        o_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_ctrl.sv
// Scoreboard bench for frame_ctrl: a byte-level frame parser model predicts pixels, line/done, err and busy.
module tb_frame_ctrl;
  localparam logic [31:0] SYNC = 32'h4245_474E;
  localparam int          TO   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] width, height;
  logic        line, done, busy, err;

  axis_if #(.W(8)) axis_i ();
  axis_if #(.W(8)) axis_o ();

  always #5 clk = ~clk;

  frame_ctrl #(.SYNC(SYNC), .DIM_W(32), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .axis_i (axis_i),
    .axis_o (axis_o),
    .width  (width),
    .height (height),
    .line   (line),
    .done   (done),
    .busy   (busy),
    .err    (err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       dn;
  } beat_t;

  beat_t       expq[$];
  int          mmode;       // 0 hunting, 1 width bytes, 2 height bytes, 3 pixels
  logic [31:0] hist, tw, th, mw, mh;
  longint      pix, total;
  int          nb, idle;
  logic        exp_err;
  logic        s_acc;
  logic [7:0]  s_byte;
  logic        held;
  logic [7:0]  held_data;
  int          rdy_mode;
  int          err_seen, done_seen, line_seen;

  task automatic model_reset();
    mmode   = 0;
    hist    = '0;
    mw      = '0;
    mh      = '0;
    nb      = 0;
    idle    = 0;
    exp_err = 1'b0;
    s_acc   = 1'b0;
    held    = 1'b0;
    expq.delete();
  endtask

  task automatic model_step();
    logic [7:0] b;
    exp_err = 1'b0;
    if (s_acc) begin
      b    = s_byte;
      idle = 0;
      case (mmode)
        0: begin
          hist = {hist[23:0], b};
          if (hist == SYNC) begin
            mmode = 1; nb = 0; tw = '0; hist = '0;
          end
        end
        1: begin
          tw = {tw[23:0], b}; nb++;
          if (nb == 4) begin
            mw = tw; mmode = 2; nb = 0; th = '0;
          end
        end
        2: begin
          th = {th[23:0], b}; nb++;
          if (nb == 4) begin
            mh = th;
            if (mw == 0 || mh == 0) begin
              exp_err = 1'b1; mmode = 0; hist = '0;
            end else begin
              mmode = 3; pix = 0; total = longint'(mw) * longint'(mh);
            end
          end
        end
        default: begin
          pix++;
          expq.push_back('{d: b, l: (pix % longint'(mw) == 0), dn: (pix == total)});
          if (pix == total) begin
            mmode = 0; hist = '0;
          end
        end
      endcase
    end
`ifdef FRAME_TIMEOUT_EN
    else if (mmode != 0) begin
      idle++;
      if (idle == TO) begin
        exp_err = 1'b1; mmode = 0; hist = '0; idle = 0;
      end
    end
`endif
  endtask

  always @(posedge clk) if (rst) model_step();

  // Sample the handshake mid-cycle, then check DUT state against the model.
  always @(negedge clk) begin
    beat_t e;
    s_acc  = rst && axis_i.vld && axis_i.rdy;
    s_byte = axis_i.data;
    if (rst) begin
      check("busy", busy, (mmode != 0));
      check("err", err, exp_err);
      if (err) err_seen++;
      if (mmode == 0 || mmode == 3) begin
        check("width", width, mw);
        check("height", height, mh);
      end
      if (mmode != 3) check("in_rdy", axis_i.rdy, 1);
      if (axis_o.vld) begin
        if (held) begin
          check("hold_data", axis_o.data, held_data);
          check("hold_line", line, 0);
          check("hold_done", done, 0);
        end else if (expq.size() == 0) begin
          check("unexpected_pixel", axis_o.data, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check("pix_data", axis_o.data, e.d);
          check("pix_line", line, e.l);
          check("pix_done", done, e.dn);
          if (line) line_seen++;
          if (done) done_seen++;
        end
        held      = !axis_o.rdy;
        held_data = axis_o.data;
      end else begin
        held = 1'b0;
        check("idle_line", line, 0);
        check("idle_done", done, 0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       axis_o.rdy = 1'b1;
      1:       axis_o.rdy = ~axis_o.rdy;
      default: axis_o.rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    int g;
    axis_i.data = b;
    axis_i.vld  = 1'b1;
    g = 0;
    forever begin
      @(negedge clk);
      if (axis_i.rdy) break;
      g++;
      if (g > 1000) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    axis_i.vld = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_r(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    send(b);
  endtask

  task automatic send32(input logic [31:0] v, input bit gaps);
    for (int i = 3; i >= 0; i--) send_r(v[8*i +: 8], gaps);
  endtask

  task automatic send_sync(input bit gaps);
    send32(SYNC, gaps);
  endtask

  task automatic junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'h42);
      send(b);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (expq.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    idle_cycles(2);
    check("drain", expq.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_err, snap_done, snap_line;
    int w, h;
    axis_i.vld  = 1'b0;
    axis_i.data = '0;
    axis_o.rdy  = 1'b1;
    rdy_mode    = 0;
    err_seen    = 0;
    done_seen   = 0;
    line_seen   = 0;
    model_reset();

    // Reset state
    idle_cycles(3);
    check("rst_vld", axis_o.vld, 0);
    check("rst_width", width, 0);
    check("rst_height", height, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_line", line, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    idle_cycles(2);

    // Header parse
    junk(10);
    send(8'h42); send(8'h45); send(8'h47);
    check("busy_before_sync", busy, 0);
    send(8'h4E);
    check("busy_after_sync", busy, 1);
    send32(32'd5, 1'b0);
    send32(32'd5, 1'b0);
    check("hdr_width", width, 5);
    check("hdr_height", height, 5);
    check("hdr_no_output", axis_o.vld, 0);

    // Pixel forwarding with toggling backpressure
    rdy_mode  = 1;
    snap_done = done_seen;
    snap_line = line_seen;
    for (int i = 0; i < 25; i++) send(8'(i));
    check("busy_after_last", busy, 0);
    drain();
    check("frame1_lines", line_seen - snap_line, 5);
    check("frame1_done", done_seen - snap_done, 1);

    // Trailing data stays in HUNT
    rdy_mode = 0;
    for (int i = 8'h19; i <= 8'hFF; i++) send(8'(i));
    idle_cycles(2);
    check("trail_busy", busy, 0);
    check("trail_vld", axis_o.vld, 0);

    // Overlapping sync prefix and zero-size header
    snap_err = err_seen;
    send(8'h42); send(8'h42); send(8'h45); send(8'h47); send(8'h4E);
    send32(32'd0, 1'b0);
    send32(32'd3, 1'b0);
    idle_cycles(2);
    check("zero_err_once", err_seen - snap_err, 1);
    check("zero_width", width, 0);
    check("zero_height", height, 3);
    check("zero_busy", busy, 0);

    // Asynchronous reset mid-frame
    send_sync(1'b0);
    send32(32'd5, 1'b0);
    send32(32'd5, 1'b0);
    for (int i = 0; i < 8; i++) send(8'(i));
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_vld", axis_o.vld, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_width", width, 0);
    check("mid_rst_height", height, 0);
    check("mid_rst_line", line, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err", err, 0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(1);
    rdy_mode  = 2;
    snap_done = done_seen;
    send_sync(1'b1);
    send32(32'd5, 1'b1);
    send32(32'd5, 1'b1);
    for (int i = 0; i < 25; i++) send_r(8'($urandom_range(0, 255)), 1'b1);
    drain();
    check("post_rst_done", done_seen - snap_done, 1);

    // Random frames, including 1-wide and 1-high boundaries
    snap_done = done_seen;
    for (int f = 0; f < 6; f++) begin
      w = (f == 0) ? 1 : (f == 1) ? 1 : (f == 2) ? 4 : $urandom_range(1, 4);
      h = (f == 0) ? 1 : (f == 1) ? 4 : (f == 2) ? 1 : $urandom_range(1, 4);
      junk($urandom_range(0, 5));
      send_sync(1'b1);
      send32(32'(w), 1'b1);
      send32(32'(h), 1'b1);
      for (int i = 0; i < w * h; i++) send_r(8'($urandom_range(0, 255)), 1'b1);
    end
    drain();
    check("rand_frames_done", done_seen - snap_done, 6);

`ifdef FRAME_TIMEOUT_EN
    // Idle timeout mid-frame
    rdy_mode = 0;
    idle_cycles(2);
    send_sync(1'b0);
    send32(32'd5, 1'b0);
    send32(32'd5, 1'b0);
    for (int i = 0; i < 3; i++) send(8'(8'hA0 + i));
    snap_err  = err_seen;
    snap_done = done_seen;
    idle_cycles(60);
    check("to_err_once", err_seen - snap_err, 1);
    check("to_no_done", done_seen - snap_done, 0);
    check("to_busy", busy, 0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frame_ctrl.md
Name: frame_ctrl

Overview:
- Sequences the pixel data_path. Hunts the incoming byte stream for the frame sync word, then captures the 32-bit width and height fields.
- Forwards exactly width*height pixel bytes to the data_path and drops everything else.
- Generates per-row line and per-frame done pulses for the downstream filter.
- Sits between the byte-stream receiver and data_path, on axis_if byte streams.

Parameters:
- SYNC, 32'h4245_474E, frame sync word ("BEGN"), first byte = MSB.
- DIM_W, 32, width of the width/height fields and the row/column counters. Header fields are always 4 bytes; bits above DIM_W are ignored.
- TIMEOUT, 1_000_000, idle-cycle limit. Used only with FRAME_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- axis_i  axis_if slave  8  byte stream in (data, vld, rdy)
- axis_o  axis_if master  8  pixel stream to data_path (data, vld, rdy)
- width  out  DIM_W  captured frame width in pixels
- height  out  DIM_W  captured frame height in rows
- line  out  1  one-cycle pulse, last pixel of a row
- done  out  1  one-cycle pulse, last pixel of the frame
- busy  out  1  high outside HUNT
- err  out  1  one-cycle pulse on zero dimension or timeout

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-frame):
  - state=HUNT.
  - axis_o.vld, width, height, line, done, err, busy all 0.
  - Counters and sync shift register cleared.
- A beat is accepted when vld&&rdy on the same posedge.
- HUNT:
  - axis_i.rdy=1; bytes are consumed and dropped.
  - 32-bit shift register of accepted bytes. Match when {shreg[23:0], data}==SYNC, so overlapping prefixes work (42 42 45 47 4E matches).
  - On match, go to WIDTH with byte counter 0.
- WIDTH:
  - axis_i.rdy=1; 4 accepted bytes are shifted MSB-first into width.
  - After the 4th byte, go to HEIGHT.
- HEIGHT:
  - Same as WIDTH, loading height.
  - After the 4th byte: if width==0 or height==0, pulse err and go to HUNT; else go to PIXELS with col=0, row=0.
- PIXELS:
  - One-stage output register, latency 1 cycle from input accept to axis_o.vld.
  - axis_i.rdy = !axis_o.vld || axis_o.rdy, allowing full-throughput back-to-back transfer.
  - axis_o.data and axis_o.vld hold stable while axis_o.rdy=0.
  - On each accepted pixel: col++.
  - If col==width-1: col=0, row++, and line is registered high in the same cycle the pixel is loaded into the output register (line is coincident with the first cycle of that axis_o.vld).
  - If additionally row==height-1: done pulses with that line, and state returns to HUNT (the shift register is cleared).
- After done:
  - The output register still drains its final pixel under backpressure.
  - HUNT does not wait for the drain; axis_i.rdy=1 in HUNT, and HUNT never writes the output register.
- Sync bytes inside pixel data are plain pixels; there is no resync in PIXELS.
- width and height hold their last loaded values until the next header overwrites them, including a rejected zero-size header.
- busy = (state != HUNT).
- line, done and err are single-cycle, registered pulses.

Optional Feature:
- FRAME_TIMEOUT_EN defined:
  - An idle counter increments each cycle in WIDTH, HEIGHT or PIXELS with no accepted axis_i beat, and clears on any accepted beat.
  - At TIMEOUT: pulse err and go to HUNT. Any pending output pixel still drains, and no done is issued.
- FRAME_TIMEOUT_EN undefined: no counter; the block waits indefinitely.

Test Plan:
- Header parse: 10 random non-sync bytes, then 42 45 47 4E, then 00 00 00 05, then 00 00 00 05 -> width=5, height=5; busy rises the cycle after 4E is accepted; nothing appears on axis_o.
- Pixel forwarding: bytes 00..18 after the header, axis_o.rdy toggling every cycle -> axis_o emits 00..18 in order with no loss or duplication. line pulses with pixels 04, 09, 0E, 13, 18; done pulses with 18; busy falls after 18 is accepted.
- Trailing data: bytes 19..FF after done -> axis_i.rdy=1 throughout; axis_o.vld stays 0; the block stays in HUNT.
- Overlap and zero size: 42 42 45 47 4E, then width 00000000, then height 00000003 -> err pulses once; returns to HUNT; width=0, height=3.
- Reset mid-frame: rst low asynchronously after pixel 07 of a 5x5 frame -> all outputs 0 immediately; a new full header plus 25 pixels then completes normally with done.
- Timeout (FRAME_TIMEOUT_EN, TIMEOUT=50): header 5x5, 3 pixels, then 60 idle cycles -> err on idle cycle 50; state HUNT; no done.
